// File: rtl/tile_rd_sched_pkg.sv
// Shared definitions for the tile read scheduler and its counter.
// Optional build macro: TILE_RD_SCHED_WDOG_EN widens err by one watchdog bit.
package tile_rd_sched_pkg;

  localparam int DEF_DATA_W        = 64;
  localparam int DEF_MAX_TILE_SIZE = 64;
  localparam int DEF_MAX_TILES     = 4096;
  localparam int DEF_WDOG_CYCLES   = 1024;

  // Bit positions inside the sticky error vector
  localparam int ERR_BAD_CFG    = 0;
  localparam int ERR_OVERLAP    = 1;
  localparam int ERR_UNEXP_WORD = 2;
  localparam int ERR_WDOG       = 3;

`ifdef TILE_RD_SCHED_WDOG_EN
  localparam int ERR_W = 4;
`else
  localparam int ERR_W = 3;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/tile_rd_sched_if.sv
// Buffer-facing read port of the tile read scheduler.
// The scheduler is the master: it requests tiles and presents the tile size,
// the buffer answers with readiness flags and the returning tile words.
interface tile_rd_sched_if #(
  parameter int DATA_W = 64,
  parameter int TS_W   = 6
);

  logic              start_tile_rd;
  logic [TS_W-1:0]   tile_size;
  logic              tile_size_valid;
  logic              tile_rd_ready;
  logic              two_tiles_rd_ready;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;

  modport master (
    output start_tile_rd, tile_size, tile_size_valid,
    input  tile_rd_ready, two_tiles_rd_ready, in_valid, in_data
  );

  modport slave (
    input  start_tile_rd, tile_size, tile_size_valid,
    output tile_rd_ready, two_tiles_rd_ready, in_valid, in_data
  );

endinterface

// File: rtl/tile_word_counter.sv
// Counts accepted words within a tile and tiles within a layer, and produces
// the registered tile/layer boundary markers that travel with the output word.
module tile_word_counter
  import tile_rd_sched_pkg::*;
#(
  parameter int TS_W  = $clog2(DEF_MAX_TILE_SIZE),
  parameter int CNT_W = $clog2(DEF_MAX_TILES) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             word_valid,
  input  logic [TS_W-1:0]  tile_size,
  input  logic [CNT_W-1:0] tiles_total,
  output logic             tile_done,
  output logic             out_tile_last,
  output logic             out_layer_last
);

  logic [TS_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] tiles_rx_q, tiles_rx_d;
  logic             tile_last_q, tile_last_d;
  logic             layer_last_q, layer_last_d;
  logic             layer_last;

  // Detect tile/layer completion and advance the word and tile counters
  always_comb begin
    word_cnt_d   = word_cnt_q;
    tiles_rx_d   = tiles_rx_q;
    tile_done    = word_valid && (word_cnt_q == tile_size - 1'b1);
    layer_last   = tile_done && (tiles_rx_q == tiles_total - 1'b1);
    tile_last_d  = tile_done;
    layer_last_d = layer_last;
    if (clear) begin
      word_cnt_d = '0;
      tiles_rx_d = '0;
    end else if (word_valid) begin
      if (tile_done) begin
        word_cnt_d = '0;
        tiles_rx_d = tiles_rx_q + 1'b1;
      end else begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end
  end

  // Counter and marker registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_cnt_q   <= '0;
      tiles_rx_q   <= '0;
      tile_last_q  <= 1'b0;
      layer_last_q <= 1'b0;
    end else begin
      word_cnt_q   <= word_cnt_d;
      tiles_rx_q   <= tiles_rx_d;
      tile_last_q  <= tile_last_d;
      layer_last_q <= layer_last_d;
    end
  end

  assign out_tile_last  = tile_last_q;
  assign out_layer_last = layer_last_q;

endmodule

// File: rtl/tile_rd_sched.sv
// Tile read scheduler: requests tiles from the layer tile buffer keeping up to
// two in flight, forwards returning words one cycle later with boundary
// markers, and flags protocol errors in a sticky vector.
// Optional build macro: TILE_RD_SCHED_WDOG_EN adds a no-data watchdog (err[3]).
module tile_rd_sched
  import tile_rd_sched_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAX_TILE_SIZE = DEF_MAX_TILE_SIZE,
  parameter int MAX_TILES     = DEF_MAX_TILES
`ifdef TILE_RD_SCHED_WDOG_EN
  ,
  parameter int WDOG_CYCLES   = DEF_WDOG_CYCLES
`endif
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             layer_start,
  input  logic [$clog2(MAX_TILE_SIZE)-1:0] cfg_tile_size,
  input  logic [$clog2(MAX_TILES):0]       cfg_tiles,
  input  logic                             consumer_credit,
  tile_rd_sched_if.master                  rd_if,
  output logic                             out_valid,
  output logic [DATA_W-1:0]                out_data,
  output logic                             out_tile_last,
  output logic                             out_layer_last,
  output logic                             layer_done,
  output logic                             busy,
  output logic [ERR_W-1:0]                 err
);

  localparam int TS_W  = $clog2(MAX_TILE_SIZE);
  localparam int CNT_W = $clog2(MAX_TILES) + 1;

  sched_state_e      state_q, state_d;
  logic [TS_W-1:0]   tile_size_q, tile_size_d;
  logic [CNT_W-1:0]  tiles_q, tiles_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [1:0]        outstanding_q, outstanding_d;
  logic              start_q, start_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              issue;
  logic              accept;
  logic              layer_go;
  logic              tile_done;
`ifdef TILE_RD_SCHED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              wdog_hit;
`endif

  // Next-state, issue decision, in-flight accounting and error capture
  always_comb begin
    state_d     = state_q;
    tile_size_d = tile_size_q;
    tiles_d     = tiles_q;
    issued_d    = issued_q;
    err_d       = err_q;
    layer_go    = 1'b0;

    // Words arriving with nothing requested are dropped, not forwarded
    accept = rd_if.in_valid && (outstanding_q != 2'd0);

    // The cycle after a pulse is blocked so the buffer's ready flags can settle
    issue = (state_q == RUN) && !start_q && consumer_credit &&
            (issued_q < tiles_q) &&
            (((outstanding_q == 2'd0) && rd_if.tile_rd_ready) ||
             ((outstanding_q == 2'd1) && rd_if.two_tiles_rd_ready));

    start_d       = issue;
    out_valid_d   = accept;
    out_data_d    = accept ? rd_if.in_data : out_data_q;
    outstanding_d = outstanding_q + {1'b0, issue} - {1'b0, tile_done};

    if (rd_if.in_valid && (outstanding_q == 2'd0)) begin
      err_d[ERR_UNEXP_WORD] = 1'b1;
    end
    if (layer_start && (state_q != IDLE)) begin
      err_d[ERR_OVERLAP] = 1'b1;
    end
`ifdef TILE_RD_SCHED_WDOG_EN
    if (wdog_hit) begin
      err_d[ERR_WDOG] = 1'b1;
    end
`endif
    if (issue) begin
      issued_d = issued_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (layer_start) begin
          if (cfg_tile_size == '0) begin
            err_d[ERR_BAD_CFG] = 1'b1;
          end else begin
            tile_size_d = cfg_tile_size;
            tiles_d     = cfg_tiles;
            issued_d    = '0;
            layer_go    = 1'b1;
            state_d     = (cfg_tiles == '0) ? DONE : RUN;
          end
        end
      end
      RUN: begin
        if (issue && ((issued_q + 1'b1) == tiles_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_layer_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scheduler state, configuration and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      tile_size_q   <= '0;
      tiles_q       <= '0;
      issued_q      <= '0;
      outstanding_q <= 2'd0;
      start_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      tile_size_q   <= tile_size_d;
      tiles_q       <= tiles_d;
      issued_q      <= issued_d;
      outstanding_q <= outstanding_d;
      start_q       <= start_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      err_q         <= err_d;
    end
  end

`ifdef TILE_RD_SCHED_WDOG_EN
  // Count consecutive silent cycles while tiles are in flight
  always_comb begin
    wdog_d   = '0;
    wdog_hit = 1'b0;
    if ((outstanding_q != 2'd0) && !rd_if.in_valid) begin
      if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
        wdog_hit = 1'b1;
        wdog_d   = wdog_q;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  tile_word_counter #(
    .TS_W  (TS_W),
    .CNT_W (CNT_W)
  ) u_word_counter (
    .clk            (clk),
    .resetn         (resetn),
    .clear          (layer_go),
    .word_valid     (accept),
    .tile_size      (tile_size_q),
    .tiles_total    (tiles_q),
    .tile_done      (tile_done),
    .out_tile_last  (out_tile_last),
    .out_layer_last (out_layer_last)
  );

  assign rd_if.start_tile_rd   = start_q;
  assign rd_if.tile_size       = tile_size_q;
  assign rd_if.tile_size_valid = (state_q == RUN) || (state_q == DRAIN);
  assign out_valid             = out_valid_q;
  assign out_data              = out_data_q;
  assign layer_done            = (state_q == DONE);
  assign busy                  = (state_q != IDLE);
  assign err                   = err_q;

endmodule
